// File: rtl/systolic_array_os.sv
// Output-stationary X_ROW x Y_COL systolic multiplier with its own sequencer; optional SA_ACC_SATURATE_EN clamps accumulators.
// Latency: done pulses after edge N+1 (start edge = 0), N = X_ROW+Y_COL+XCOL_YROW-2; Z held until next start.
// No backpressure: start is accepted only in IDLE, ignored while busy, never queued.
module systolic_array_os #(
  parameter int BITWIDTH  = 8,
  parameter int X_ROW     = 3,
  parameter int XCOL_YROW = 3,
  parameter int Y_COL     = 3,
  parameter int ACC_WIDTH = 2*BITWIDTH+2
) (
  input  logic                               sys_clk,
  input  logic                               sys_rst_n,
  input  logic                               start,
  input  logic [X_ROW*BITWIDTH-1:0]          in_row,
  input  logic [Y_COL*BITWIDTH-1:0]          in_col,
  output logic                               calculate_flag,
  output logic                               busy,
  output logic                               done,
  output logic [X_ROW*Y_COL*ACC_WIDTH-1:0]   Z
);

  localparam int N     = X_ROW + Y_COL + XCOL_YROW - 2;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam int PW    = 2*BITWIDTH;
  localparam int ZW    = X_ROW*Y_COL*ACC_WIDTH;
  localparam int AP    = (Y_COL > 1) ? Y_COL-1 : 1;
  localparam int BP    = (X_ROW > 1) ? X_ROW-1 : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N-1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_COMPUTE, S_DONE} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             clear;

  logic signed [BITWIDTH-1:0]  a_in    [X_ROW][Y_COL];
  logic signed [BITWIDTH-1:0]  b_in    [X_ROW][Y_COL];
  logic signed [BITWIDTH-1:0]  a_pipe  [X_ROW][AP];
  logic signed [BITWIDTH-1:0]  b_pipe  [BP][Y_COL];
  logic signed [ACC_WIDTH-1:0] acc_q   [X_ROW][Y_COL];
  logic signed [ACC_WIDTH-1:0] acc_nxt [X_ROW][Y_COL];

  // calculate_flag is registered straight from the next state so upstream sees it exactly during COMPUTE.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state          <= S_IDLE;
      cnt            <= '0;
      calculate_flag <= 1'b0;
    end else begin
      state          <= state_nxt;
      calculate_flag <= (state_nxt == S_COMPUTE);
      if (state == S_LOAD)
        cnt <= '0;
      else if (state == S_COMPUTE)
        cnt <= cnt + CNT_W'(1);
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (start) state_nxt = S_LOAD;
      S_LOAD:    state_nxt = S_COMPUTE;
      S_COMPUTE: if (cnt == CNT_LAST) state_nxt = S_DONE;
      S_DONE:    state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy  = (state != S_IDLE);
    done  = (state == S_DONE);
    clear = (state == S_IDLE) && start;
  end

  genvar gi, gj;
  generate
    for (gi = 0; gi < X_ROW; gi++) begin : g_row
      for (gj = 0; gj < Y_COL; gj++) begin : g_col
        logic signed [PW-1:0] prod;

        if (gj == 0) begin : g_a_edge
          assign a_in[gi][gj] = in_row[(X_ROW*BITWIDTH-1)-gi*BITWIDTH -: BITWIDTH];
        end else begin : g_a_mid
          assign a_in[gi][gj] = a_pipe[gi][gj-1];
        end

        if (gi == 0) begin : g_b_edge
          assign b_in[gi][gj] = in_col[(Y_COL*BITWIDTH-1)-gj*BITWIDTH -: BITWIDTH];
        end else begin : g_b_mid
          assign b_in[gi][gj] = b_pipe[gi-1][gj];
        end

        assign prod = a_in[gi][gj] * b_in[gi][gj];

`ifdef SA_ACC_SATURATE_EN
        // One guard bit exposes overflow; clamp toward the sign the true sum would have had.
        logic signed [ACC_WIDTH:0] sum;
        assign sum = (ACC_WIDTH+1)'(acc_q[gi][gj]) + (ACC_WIDTH+1)'(prod);
        assign acc_nxt[gi][gj] = (sum[ACC_WIDTH] != sum[ACC_WIDTH-1])
                               ? (sum[ACC_WIDTH] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                                                 : {1'b0, {(ACC_WIDTH-1){1'b1}}})
                               : sum[ACC_WIDTH-1:0];
`else
        assign acc_nxt[gi][gj] = acc_q[gi][gj] + ACC_WIDTH'(prod);
`endif

        assign Z[(ZW-1)-(gi*Y_COL+gj)*ACC_WIDTH -: ACC_WIDTH] = acc_q[gi][gj];
      end
    end
  endgenerate

  // Pass-through registers exist only where a neighbour consumes them.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      acc_q  <= '{default: '0};
      a_pipe <= '{default: '0};
      b_pipe <= '{default: '0};
    end else if (clear) begin
      acc_q  <= '{default: '0};
      a_pipe <= '{default: '0};
      b_pipe <= '{default: '0};
    end else if (calculate_flag) begin
      acc_q <= acc_nxt;
      for (int i = 0; i < X_ROW; i++)
        for (int j = 0; j < Y_COL-1; j++)
          a_pipe[i][j] <= a_in[i][j];
      for (int i = 0; i < X_ROW-1; i++)
        for (int j = 0; j < Y_COL; j++)
          b_pipe[i][j] <= b_in[i][j];
    end
  end

endmodule

// File: tb/tb_systolic_array_os.sv
// Bench for systolic_array_os: three instances (3x3x3, 2x4x3, 3x3x3 with 16-bit accumulators)
// driven with skewed lanes and compared against a plain matrix-product reference.
module tb_systolic_array_os;

`ifdef SA_ACC_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;

  logic         start_a, cf_a, busy_a, done_a;
  logic [23:0]  row_a, col_a;
  logic [161:0] z_a;
  logic         start_b, cf_b, busy_b, done_b;
  logic [15:0]  row_b;
  logic [23:0]  col_b;
  logic [107:0] z_b;
  logic         start_c, cf_c, busy_c, done_c;
  logic [23:0]  row_c, col_c;
  logic [143:0] z_c;

  int nvec = 0;
  int nerr = 0;
  int xm [4][4];
  int ym [4][4];

  systolic_array_os u_a (
    .sys_clk(clk), .sys_rst_n(rst_n), .start(start_a), .in_row(row_a), .in_col(col_a),
    .calculate_flag(cf_a), .busy(busy_a), .done(done_a), .Z(z_a));

  systolic_array_os #(.X_ROW(2), .XCOL_YROW(4), .Y_COL(3)) u_b (
    .sys_clk(clk), .sys_rst_n(rst_n), .start(start_b), .in_row(row_b), .in_col(col_b),
    .calculate_flag(cf_b), .busy(busy_b), .done(done_b), .Z(z_b));

  systolic_array_os #(.ACC_WIDTH(16)) u_c (
    .sys_clk(clk), .sys_rst_n(rst_n), .start(start_c), .in_row(row_c), .in_col(col_c),
    .calculate_flag(cf_c), .busy(busy_c), .done(done_c), .Z(z_c));

  always #5 clk = ~clk;

  task automatic check(input string tag, input longint obs, input longint exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic set_start(input int w, input logic v);
    case (w)
      0: start_a = v;
      1: start_b = v;
      default: start_c = v;
    endcase
  endtask

  task automatic set_lanes(input int w, input logic [31:0] r, input logic [31:0] c);
    case (w)
      0: begin row_a = r[23:0]; col_a = c[23:0]; end
      1: begin row_b = r[15:0]; col_b = c[23:0]; end
      default: begin row_c = r[23:0]; col_c = c[23:0]; end
    endcase
  endtask

  function automatic logic get_cf(input int w);
    return (w == 0) ? cf_a : (w == 1) ? cf_b : cf_c;
  endfunction

  function automatic logic get_done(input int w);
    return (w == 0) ? done_a : (w == 1) ? done_b : done_c;
  endfunction

  function automatic logic get_busy(input int w);
    return (w == 0) ? busy_a : (w == 1) ? busy_b : busy_c;
  endfunction

  function automatic logic [255:0] get_z(input int w);
    return (w == 0) ? 256'(z_a) : (w == 1) ? 256'(z_b) : 256'(z_c);
  endfunction

  // Upstream skew: at compute step t, row lane s carries X[s][t-s], column lane q carries Y[t-q][q].
  function automatic logic [31:0] lanes_row(input int t, input int r, input int k);
    logic [31:0] v = '0;
    logic [7:0]  b;
    for (int s = 0; s < r; s++) begin
      b = (t-s >= 0 && t-s < k) ? 8'(xm[s][t-s]) : 8'd0;
      v = (v << 8) | {24'd0, b};
    end
    return v;
  endfunction

  function automatic logic [31:0] lanes_col(input int t, input int c, input int k);
    logic [31:0] v = '0;
    logic [7:0]  b;
    for (int q = 0; q < c; q++) begin
      b = (t-q >= 0 && t-q < k) ? 8'(ym[t-q][q]) : 8'd0;
      v = (v << 8) | {24'd0, b};
    end
    return v;
  endfunction

  function automatic longint ref_elem(input int i, input int j, input int k, input int w, input bit sat);
    longint acc = 0;
    longint hi  = (longint'(1) << (w-1)) - 1;
    longint lo  = -(longint'(1) << (w-1));
    for (int kk = 0; kk < k; kk++) begin
      acc += longint'(xm[i][kk]) * longint'(ym[kk][j]);
      if (sat) begin
        if (acc > hi) acc = hi;
        if (acc < lo) acc = lo;
      end else begin
        acc = acc & ((longint'(1) << w) - 1);
        if (acc > hi) acc -= (longint'(1) << w);
      end
    end
    return acc;
  endfunction

  function automatic longint zel(input logic [255:0] z, input int n, input int idx, input int w);
    logic [255:0] s = z >> ((n-1-idx)*w);
    longint v = longint'(s[63:0]) & ((longint'(1) << w) - 1);
    if (v >= (longint'(1) << (w-1))) v -= (longint'(1) << w);
    return v;
  endfunction

  task automatic check_z(input int w, input int r, input int k, input int c, input int aw, input string tag);
    logic [255:0] z = get_z(w);
    for (int i = 0; i < r; i++)
      for (int j = 0; j < c; j++)
        check($sformatf("%s_z%0d%0d", tag, i, j), zel(z, r*c, i*c+j, aw), ref_elem(i, j, k, aw, SAT));
  endtask

  function automatic int rnd8();
    return int'($urandom_range(0, 255)) - 128;
  endfunction

  task automatic fill_rand(input int r, input int k, input int c);
    for (int i = 0; i < r; i++) for (int kk = 0; kk < k; kk++) xm[i][kk] = rnd8();
    for (int kk = 0; kk < k; kk++) for (int j = 0; j < c; j++) ym[kk][j] = rnd8();
  endtask

  task automatic fill_const(input int xv, input int yv);
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        xm[i][j] = xv;
        ym[i][j] = yv;
      end
  endtask

  // Entered and left at #1 after a rising edge; loop index e is the edge just passed (edge 0 samples start).
  task automatic run_op(input int w, input int r, input int k, input int c, input int aw,
                        input bit poke, input string tag);
    int t = 0;
    int cf_n = 0;
    int de = -1;
    set_start(w, 1'b1);
    for (int e = 0; e < 40 && de < 0; e++) begin
      @(posedge clk); #1;
      if (e == 0) set_start(w, 1'b0);
      if (poke && e == 3) set_start(w, 1'b1);
      if (poke && e == 4) set_start(w, 1'b0);
      if (get_cf(w)) begin
        set_lanes(w, lanes_row(t, r, k), lanes_col(t, c, k));
        t++;
        cf_n++;
      end else begin
        set_lanes(w, '0, '0);
      end
      if (get_done(w)) de = e;
    end
    check({tag, "_done_edge"}, de, r + c + k - 1);
    check({tag, "_cf_cycles"}, cf_n, r + c + k - 2);
    check_z(w, r, k, c, aw, tag);
    for (int e = 0; e < 3; e++) begin
      @(posedge clk); #1;
      check($sformatf("%s_no_extra_done%0d", tag, e), longint'(get_done(w)), 0);
    end
    check({tag, "_idle_busy"}, longint'(get_busy(w)), 0);
  endtask

  initial begin
    int dq[$];
    int t;

    rst_n = 1'b0;
    start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
    row_a = '0; col_a = '0; row_b = '0; col_b = '0; row_c = '0; col_c = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_cf", longint'(cf_a), 0);
    check("rst_busy", longint'(busy_a), 0);
    check("rst_done", longint'(done_a), 0);
    check("rst_z", longint'(|z_a), 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // Identity Y returns X; start poked mid-compute must be ignored.
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++) begin
        xm[i][j] = i*3 + j + 1;
        ym[i][j] = (i == j) ? 1 : 0;
      end
    run_op(0, 3, 3, 3, 18, 1'b1, "ident");
    check("ident_z22_is_9", zel(get_z(0), 9, 8, 18), 9);

    fill_const(-128, -128);
    run_op(0, 3, 3, 3, 18, 1'b0, "neg_neg");
    check("neg_neg_z00_const", zel(get_z(0), 9, 0, 18), 49152);

    fill_const(127, -128);
    run_op(0, 3, 3, 3, 18, 1'b0, "pos_neg");
    check("pos_neg_z11_const", zel(get_z(0), 9, 4, 18), -48768);

    fill_const(-128, -128);
    run_op(2, 3, 3, 3, 16, 1'b0, "acc16");
    check("acc16_z00_const", zel(get_z(2), 9, 0, 16), SAT ? 32767 : -16384);

    for (int n = 0; n < 2; n++) begin
      fill_rand(3, 3, 3);
      run_op(0, 3, 3, 3, 18, 1'b0, $sformatf("rand_a%0d", n));
      fill_rand(2, 4, 3);
      run_op(1, 2, 4, 3, 18, 1'b0, $sformatf("rand_b%0d", n));
    end
    fill_rand(3, 3, 3);
    run_op(2, 3, 3, 3, 16, 1'b0, "rand_c");

    // start held high: operations every 10 cycles, done after edges 8, 18, 28.
    start_a = 1'b1;
    for (int e = 0; e <= 30; e++) begin
      @(posedge clk); #1;
      if (e == 28) start_a = 1'b0;
      if (done_a) dq.push_back(e);
    end
    check("b2b_done_count", dq.size(), 3);
    check("b2b_done0", (dq.size() > 0) ? dq[0] : -1, 8);
    check("b2b_done1", (dq.size() > 1) ? dq[1] : -1, 18);
    check("b2b_done2", (dq.size() > 2) ? dq[2] : -1, 28);
    check("b2b_idle_busy", longint'(busy_a), 0);

    // Reset during COMPUTE at cnt=3 (after edge 4), then a fresh operation.
    fill_rand(3, 3, 3);
    t = 0;
    start_a = 1'b1;
    for (int e = 0; e <= 4; e++) begin
      @(posedge clk); #1;
      if (e == 0) start_a = 1'b0;
      if (cf_a) begin
        set_lanes(0, lanes_row(t, 3, 3), lanes_col(t, 3, 3));
        t++;
      end
    end
    check("mid_cf_before_rst", longint'(cf_a), 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_cf", longint'(cf_a), 0);
    check("mid_rst_busy", longint'(busy_a), 0);
    check("mid_rst_done", longint'(done_a), 0);
    check("mid_rst_z", longint'(|z_a), 0);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    set_lanes(0, '0, '0);
    fill_rand(3, 3, 3);
    run_op(0, 3, 3, 3, 18, 1'b0, "after_rst");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
